// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Serial program loader for the HRM CPU program RAM. Accepts a
//            SYNC/LEN/data/CK byte frame, writes the payload from address 0,
//            verifies an 8-bit additive checksum and holds the CPU while
//            loading. When idle the CPU program counter drives the RAM address.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int         addr_width = 8,
    parameter logic [7:0] SYNC       = 8'hA5,
    parameter int         TIMEOUT    = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [addr_width-1:0] pc,
    output logic [addr_width-1:0] prog_addr,
    output logic [7:0]            prog_din,
    output logic                  prog_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_len  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_ck   = 2'd3;

    localparam int                  c_tmo_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_one = c_tmo_w'(1);
    localparam logic [addr_width:0] c_cnt_one = (addr_width + 1)'(1);
    localparam logic [32:0]         c_depth   = 33'd1 << addr_width;

    logic [1:0]            r_state;
    logic [7:0]            r_len;
    logic [7:0]            r_sum;
    logic [addr_width:0]   r_cnt;
    logic [addr_width-1:0] r_wr_addr;
    logic [c_tmo_w-1:0]    r_tmo;

    logic w_len_ok;
    logic w_last;
    logic w_tmo_fire;

    // Payload of LEN+1 bytes must fit in the RAM; the last data byte is the
    // one whose index equals LEN. A byte on the expiry cycle wins over timeout.
    assign w_len_ok   = ({25'd0, rx_data} + 33'd1) <= c_depth;
    assign w_last     = 32'(r_cnt) == 32'(r_len);
    assign w_tmo_fire = (r_state != c_st_idle) && !rx_valid
                        && (32'(r_tmo) == TIMEOUT - 1);

    // RAM address: loader owns the bus while holding the CPU or writing.
    assign prog_addr = (cpu_hold || prog_we) ? r_wr_addr : pc;

    // Silence counter: holds the number of clock edges since the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (rx_valid) begin
            r_tmo <= c_tmo_one;
        end else if (r_state != c_st_idle) begin
            r_tmo <= r_tmo + c_tmo_one;
        end
    end

    // Frame parser, RAM write port and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_len     <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_wr_addr <= '0;
            prog_din  <= '0;
            prog_we   <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            prog_we <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (rx_valid && rx_data == SYNC) begin
                        r_state  <= c_st_len;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                    end
                end
                c_st_len: begin
                    if (rx_valid) begin
                        r_len <= rx_data;
                        if (w_len_ok) begin
                            r_cnt   <= '0;
                            r_sum   <= '0;
                            r_state <= c_st_data;
                        end else begin
                            err     <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end else if (w_tmo_fire) begin
                        err     <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                c_st_data: begin
                    if (rx_valid) begin
                        prog_we   <= 1'b1;
                        prog_din  <= rx_data;
                        r_wr_addr <= r_cnt[addr_width-1:0];
                        r_sum     <= r_sum + rx_data;
                        r_cnt     <= r_cnt + c_cnt_one;
                        if (w_last) begin
                            r_state <= c_st_ck;
                        end
                    end else if (w_tmo_fire) begin
                        err     <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                c_st_ck: begin
                    if (rx_valid) begin
                        if (rx_data == r_sum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end else if (w_tmo_fire) begin
                        err     <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Directed self-checking bench for prog_loader (addr_width=4,
//            TIMEOUT=8) with a behavioural program RAM on the write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] pc;
    logic [3:0] prog_addr;
    logic [7:0] prog_din;
    logic       prog_we;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [7:0] ram [16];

    prog_loader #(
        .addr_width (4),
        .SYNC       (8'hA5),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pc        (pc),
        .prog_addr (prog_addr),
        .prog_din  (prog_din),
        .prog_we   (prog_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Program RAM model plus write/done event counters.
    always @(posedge clk) begin
        if (prog_we) begin
            ram[prog_addr] <= prog_din;
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; returns in the following cycle, where the
    // registered response to that byte is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        pc       = 4'd3;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_we",   prog_we,   0);
        check("rst_din",  prog_din,  0);
        check("rst_hold", cpu_hold,  0);
        check("rst_done", done,      0);
        check("rst_err",  err,       0);
        check("rst_addr", prog_addr, 3);
        rst_n = 1'b1;

        // Good frame
        send(8'hA5);
        check("g_hold_up", cpu_hold, 1);
        send(8'h02);
        check("g_len_nowe", prog_we, 0);
        send(8'h11);
        check("g_we0", prog_we, 1);
        check("g_addr0", prog_addr, 0);
        check("g_din0", prog_din, 8'h11);
        @(negedge clk);
        check("g_we_pulse", prog_we, 0);
        send(8'h22);
        check("g_addr1", prog_addr, 1);
        check("g_din1", prog_din, 8'h22);
        send(8'h33);
        check("g_addr2", prog_addr, 2);
        check("g_din2", prog_din, 8'h33);
        send(8'h66);
        check("g_done", done, 1);
        check("g_hold_dn", cpu_hold, 0);
        check("g_err", err, 0);
        @(negedge clk);
        check("g_done_pulse", done, 0);
        check("g_wr_cnt", wr_cnt, 3);
        check("g_done_cnt", done_cnt, 1);
        pc = 4'd0; #1 check("g_rd0", ram[prog_addr], 8'h11);
        pc = 4'd1; #1 check("g_rd1", ram[prog_addr], 8'h22);
        pc = 4'd2; #1 check("g_rd2", ram[prog_addr], 8'h33);

        // Bad checksum, then recovery
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
        send(8'h67);
        check("b_err", err, 1);
        check("b_hold", cpu_hold, 1);
        check("b_done", done, 0);
        check("b_wr_cnt", wr_cnt, 6);
        send(8'hA5);
        check("b_err_clr", err, 0);
        send(8'h00); send(8'h5A); send(8'h5A);
        check("r_done", done, 1);
        check("r_hold", cpu_hold, 0);

        // Noise and embedded sync
        send(8'h00);
        send(8'hFF);
        check("n_hold", cpu_hold, 0);
        check("n_we", prog_we, 0);
        w0 = wr_cnt;
        send(8'hA5); send(8'h00); send(8'hA5);
        check("n_addr", prog_addr, 0);
        check("n_din", prog_din, 8'hA5);
        send(8'hA5);
        check("n_done", done, 1);
        check("n_wr_cnt", wr_cnt - w0, 1);

        // Oversize length: 17 bytes into a 16-entry RAM
        w0 = wr_cnt;
        send(8'hA5); send(8'h10);
        check("o_err", err, 1);
        check("o_hold", cpu_hold, 1);
        repeat (2) @(negedge clk);
        check("o_wr_cnt", wr_cnt - w0, 0);

        // Largest legal frame: 16 bytes 1..16, sum 0x88
        w0 = wr_cnt;
        send(8'hA5); send(8'h0F);
        for (int i = 1; i <= 16; i++) send(8'(i));
        check("m_addr15", prog_addr, 15);
        check("m_din15", prog_din, 8'h10);
        send(8'h88);
        check("m_done", done, 1);
        check("m_err", err, 0);
        check("m_wr_cnt", wr_cnt - w0, 16);
        pc = 4'd15; #1 check("m_rd15", ram[prog_addr], 8'h10);

        // Timeout fires 8 cycles after the last byte
        send(8'hA5); send(8'h01); send(8'h42);
        repeat (6) @(negedge clk);
        check("t_pre", err, 0);
        @(negedge clk);
        check("t_err", err, 1);
        check("t_hold", cpu_hold, 1);

        // Byte on the expiry cycle continues the frame
        send(8'hA5); send(8'h01); send(8'h42);
        repeat (5) @(negedge clk);
        send(8'h13);
        check("t2_err", err, 0);
        check("t2_we", prog_we, 1);
        check("t2_addr", prog_addr, 1);
        send(8'h55);
        check("t2_done", done, 1);

        // Asynchronous reset in the middle of DATA
        pc = 4'd9;
        send(8'hA5); send(8'h03); send(8'h01); send(8'h02);
        check("x_we_pre", prog_we, 1);
        #1 rst_n = 1'b0;
        #1;
        check("x_we", prog_we, 0);
        check("x_hold", cpu_hold, 0);
        check("x_addr", prog_addr, 9);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hA5); send(8'h00); send(8'h77);
        check("x_din", prog_din, 8'h77);
        send(8'h77);
        check("x_done", done, 1);
        pc = 4'd0; #1 check("x_rd0", ram[prog_addr], 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the HRM CPU program memory. It accepts a framed byte stream from the UART receiver and writes the payload sequentially into the program RAM through that RAM's `din`/`Addr`/`write_en` port, checking a trailing checksum. While a frame is being loaded it holds the CPU and owns the RAM address bus. When idle it passes the CPU program counter through to the RAM address.

## Interface
- `addr_width`, default 8: program RAM address width; must match the RAM instance.
- `SYNC`, default 8'hA5: frame start byte.
- `TIMEOUT`, default 1_000_000: maximum idle cycles between bytes inside a frame; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle. No backpressure.
- `pc` in addr_width: CPU program address, passed through when not loading.
- `prog_addr` out addr_width: to RAM `Addr`.
- `prog_din` out 8: to RAM `din`.
- `prog_we` out 1: to RAM `write_en`.
- `cpu_hold` out 1: 1 = CPU must stall / stay in reset.
- `done` out 1: one-cycle pulse on a good frame.
- `err` out 1: sticky error flag.

## Operation
- Frame format: `SYNC`, `LEN`, then `LEN+1` data bytes (1..256), then `CK`. `CK` = 8-bit sum, mod 256, of the data bytes.
- Data byte k is written to address k, starting at 0.
- States:
  - IDLE: bytes other than `SYNC` are ignored. On `SYNC`: go to LEN, set `cpu_hold`=1, clear `err`.
  - LEN: latch `LEN`. If `LEN+1 > 2^addr_width`: go to IDLE with `err`=1 and `cpu_hold` kept at 1. Otherwise clear the address counter and sum, then go to DATA.
  - DATA: for each byte, register the write (`prog_din`=byte, write address = counter), add the byte to the sum, increment the counter. After the byte with counter = `LEN`, go to CK.
  - CK: compare `CK` with the sum. On match: `done` pulse, `cpu_hold`=0, go to IDLE. On mismatch: `err`=1, `cpu_hold` stays 1, go to IDLE.
- A `SYNC` value received in LEN, DATA or CK is ordinary payload, not a restart.
- Timeout: in LEN, DATA or CK, a cycle counter resets on every `rx_valid`. When it reaches `TIMEOUT`: go to IDLE, `err`=1, `cpu_hold` stays 1.
- If `rx_valid` arrives in the same cycle the counter would expire, the byte is processed and the timeout does not fire.
- After an error, `cpu_hold` remains 1 until a later frame completes successfully. RAM contents are not restored.
- Address mux: `prog_addr` = write address while `cpu_hold`=1 or `prog_we`=1, else `pc`. The mux is combinational from registered selects.
- Sum and address counter are 8-bit and addr_width+1-bit respectively. Wrap-around cannot occur because of the length check.

## Timing
- Reset values: `prog_we`=0, `prog_din`=0, `cpu_hold`=0, `done`=0, `err`=0, state IDLE, counters 0. The CPU therefore runs the preloaded RAM image after reset.
- Reset mid-frame aborts immediately: state IDLE, `cpu_hold`=0, and any partially written RAM is left as is.
- Data byte on `rx_valid` at cycle t: `prog_we`=1 for exactly cycle t+1, with `prog_addr`/`prog_din` valid in t+1. The RAM captures the byte at the end of t+1.
- Back-to-back `rx_valid` on consecutive cycles is legal and gives consecutive writes.
- `cpu_hold` rises at t+1 after the `SYNC` byte at t.
- On a matching `CK` at t: `done`=1 and `cpu_hold`=0 in t+1. `prog_addr` returns to `pc` in t+1; the last write has already completed, since `CK` follows at least one cycle after it.
- `err` rises at t+1 after the failing event at t.

## Test plan
- Good frame: A5, 02, 11, 22, 33, CK=66 → writes 11@0, 22@1, 33@2, each as a one-cycle `prog_we`. `done` pulses once, `cpu_hold` ends 0, `err`=0. RAM readback through `pc` returns 11/22/33.
- Bad checksum: same frame with CK=67 → all three writes occur, `err`=1, `cpu_hold` stays 1, no `done`. A following good frame clears `err` and drops `cpu_hold`.
- Noise and embedded sync: bytes 00, FF before A5 are ignored. Frame A5, 00, A5, CK=A5 → single write A5@0, `done`.
- Oversize length with `addr_width`=4: A5, 10 (17 bytes) → `err`=1 one cycle after `LEN`, no writes.
- Timeout with `TIMEOUT`=8: A5, 01, 42, then silence → `err`=1 exactly 8 cycles after the last byte. A byte arriving on the expiry cycle instead continues the frame.
- Reset mid-DATA: assert `rst_n`=0 after two data bytes → `cpu_hold`=0 and `prog_we`=0 immediately (asynchronous). `prog_addr` follows `pc`, and the next `SYNC` starts a fresh frame.
